// File: rtl/instr_fetch_unit.sv
// Instruction prefetcher: reads bytes at a 4-bit PC from a 16x8 sync memory into a small FIFO for decode.
// One read in flight at a time (1+MEM_LATENCY cycles per byte); branch_valid flushes the FIFO and drops the in-flight read.
module instr_fetch_unit #(
    parameter int DEPTH       = 2,
    parameter int MEM_LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fetch_en,
    input  logic       branch_valid,
    input  logic [3:0] branch_addr,
    input  logic       instr_ready,
    output logic       instr_valid,
    output logic [7:0] instr_data,
    output logic [3:0] instr_pc,
    output logic [3:0] mem_addr,
    output logic       mem_enable,
    output logic       read_write,
    input  logic [7:0] mem_rdata
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int WW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_C    = PW'(DEPTH - 1);
    localparam logic [WW-1:0] WAIT_INIT = WW'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t         state_q, state_d;
    logic [3:0]     pc_q, pc_d;
    logic [WW-1:0]  wait_q, wait_d;
    logic [CW-1:0]  count_q, count_d, count_next;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [7:0]     data_q [DEPTH];
    logic [3:0]     addr_q [DEPTH];
    logic           mem_enable_q, mem_enable_d;
    logic [3:0]     mem_addr_q;
    logic           push, pop, wr_en;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_C) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        pop          = (count_q != '0) && instr_ready;
        push         = (state_q == WAIT) && (wait_q == '0);
        count_next   = count_q + CW'(push) - CW'(pop);
        state_d      = state_q;
        pc_d         = pc_q;
        wait_d       = wait_q;
        count_d      = count_next;
        rd_ptr_d     = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d     = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        wr_en        = push;
        mem_enable_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (fetch_en && (count_next < DEPTH_C)) state_d = REQ;
            end
            REQ: begin
                state_d = WAIT;
                wait_d  = WAIT_INIT;
            end
            WAIT: begin
                if (wait_q == '0) begin
                    pc_d    = pc_q + 4'd1;
                    state_d = (fetch_en && (count_next < DEPTH_C)) ? REQ : IDLE;
                end else begin
                    wait_d = wait_q - WW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Redirect overrides everything, including this edge's push and pop.
        if (branch_valid) begin
            state_d  = IDLE;
            pc_d     = branch_addr;
            wait_d   = '0;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            wr_en    = 1'b0;
        end

        mem_enable_d = (state_d == REQ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pc_q         <= '0;
            wait_q       <= '0;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            mem_enable_q <= 1'b0;
            mem_addr_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                addr_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            wait_q       <= wait_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            mem_enable_q <= mem_enable_d;
            mem_addr_q   <= pc_d;
            if (wr_en) begin
                data_q[wr_ptr_q] <= mem_rdata;
                addr_q[wr_ptr_q] <= pc_q;
            end
        end
    end

    assign instr_valid = (count_q != '0);
    assign instr_data  = data_q[rd_ptr_q];
    assign instr_pc    = addr_q[rd_ptr_q];
    assign mem_addr    = mem_addr_q;
    assign mem_enable  = mem_enable_q;
    assign read_write  = 1'b1;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: instance A (DEPTH=2, LAT=1) and instance B (DEPTH=3, LAT=3), each with its own memory model.
module tb_instr_fetch_unit;
    logic       clk;
    logic       rst_n;

    logic       fe_a, br_a, rdy_a, v_a, me_a, rw_a;
    logic [3:0] bra_a, p_a, ma_a;
    logic [7:0] d_a, rd_a;

    logic       fe_b, br_b, rdy_b, v_b, me_b, rw_b;
    logic [3:0] bra_b, p_b, ma_b;
    logic [7:0] d_b, rd_b;

    logic [7:0] mem [16];
    int unsigned lat_a = 0, lat_b = 0;
    logic [3:0] la_a = '0, la_b = '0;
    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [3:0] pc;
        logic [7:0] dat;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        bit         rst;
        bit         fe;
        bit         rdy;
        bit         ev;
        logic [7:0] ed;
        logic [3:0] ep;
        bit         eme;
        logic [3:0] ea;
    } vec_t;
    vec_t tv[18];

    instr_fetch_unit #(.DEPTH(2), .MEM_LATENCY(1)) u_a (
        .clk(clk), .rst_n(rst_n), .fetch_en(fe_a), .branch_valid(br_a),
        .branch_addr(bra_a), .instr_ready(rdy_a), .instr_valid(v_a),
        .instr_data(d_a), .instr_pc(p_a), .mem_addr(ma_a), .mem_enable(me_a),
        .read_write(rw_a), .mem_rdata(rd_a)
    );

    instr_fetch_unit #(.DEPTH(3), .MEM_LATENCY(3)) u_b (
        .clk(clk), .rst_n(rst_n), .fetch_en(fe_b), .branch_valid(br_b),
        .branch_addr(bra_b), .instr_ready(rdy_b), .instr_valid(v_b),
        .instr_data(d_b), .instr_pc(p_b), .mem_addr(ma_b), .mem_enable(me_b),
        .read_write(rw_b), .mem_rdata(rd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory models: data is valid only in the last latency cycle, junk otherwise.
    always @(posedge clk) begin
        if (me_a) begin lat_a <= 1; la_a <= ma_a; end
        else if (lat_a != 0) lat_a <= lat_a - 1;
        if (me_b) begin lat_b <= 3; la_b <= ma_b; end
        else if (lat_b != 0) lat_b <= lat_b - 1;
    end
    assign rd_a = (lat_a == 1) ? mem[la_a] : 8'hEE;
    assign rd_b = (lat_b == 1) ? mem[la_b] : (8'hE0 + 8'(lat_b));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        fe_a = 0; br_a = 0; bra_a = 0; rdy_a = 0;
        fe_b = 0; br_b = 0; bra_b = 0; rdy_b = 0;
        sbq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic expect_byte(input logic [3:0] pc);
        exp_t e;
        e.pc  = pc;
        e.dat = 8'h10 + 8'(pc);
        sbq.push_back(e);
    endtask

    task automatic drain(input bit use_b, input int n, input int budget, output int last_cyc);
        int got = 0;
        int waited = 0;
        exp_t e;
        logic v, r;
        logic [7:0] d;
        logic [3:0] p;
        last_cyc = -1;
        while (got < n && waited < budget) begin
            v = use_b ? v_b : v_a;
            r = use_b ? rdy_b : rdy_a;
            d = use_b ? d_b : d_a;
            p = use_b ? p_b : p_a;
            if (v && r) begin
                if (sbq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pop actual_data=0x%0h actual_pc=%0d required=none", d, p);
                end else begin
                    e = sbq.pop_front();
                    chk("pop_data", d, e.dat);
                    chk("pop_pc", p, e.pc);
                end
                got++;
                last_cyc = cyc;
            end
            @(negedge clk);
            waited++;
        end
        chk("drain_count", got, n);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t, s;
        for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);

        // Streaming (rows 0-7) then backpressure (rows 8-17), each from reset.
        tv[0]  = '{1, 1, 1, 0, 8'h00, 4'd0, 0, 4'd0};
        tv[1]  = '{0, 1, 1, 0, 8'h00, 4'd0, 1, 4'd0};
        tv[2]  = '{0, 1, 1, 0, 8'h00, 4'd0, 0, 4'd0};
        tv[3]  = '{0, 1, 1, 1, 8'h10, 4'd0, 1, 4'd1};
        tv[4]  = '{0, 1, 1, 0, 8'h00, 4'd0, 0, 4'd1};
        tv[5]  = '{0, 1, 1, 1, 8'h11, 4'd1, 1, 4'd2};
        tv[6]  = '{0, 1, 1, 0, 8'h00, 4'd0, 0, 4'd2};
        tv[7]  = '{0, 1, 1, 1, 8'h12, 4'd2, 1, 4'd3};
        tv[8]  = '{1, 1, 0, 0, 8'h00, 4'd0, 0, 4'd0};
        tv[9]  = '{0, 1, 0, 0, 8'h00, 4'd0, 1, 4'd0};
        tv[10] = '{0, 1, 0, 0, 8'h00, 4'd0, 0, 4'd0};
        tv[11] = '{0, 1, 0, 1, 8'h10, 4'd0, 1, 4'd1};
        tv[12] = '{0, 1, 0, 1, 8'h10, 4'd0, 0, 4'd1};
        tv[13] = '{0, 1, 0, 1, 8'h10, 4'd0, 0, 4'd2};
        tv[14] = '{0, 1, 1, 1, 8'h10, 4'd0, 0, 4'd2};
        tv[15] = '{0, 1, 1, 1, 8'h11, 4'd1, 1, 4'd2};
        tv[16] = '{0, 1, 1, 0, 8'h00, 4'd0, 0, 4'd2};
        tv[17] = '{0, 1, 1, 1, 8'h12, 4'd2, 1, 4'd3};

        do_reset();
        for (int i = 0; i < 18; i++) begin
            if (tv[i].rst) do_reset();
            fe_a  = tv[i].fe;
            rdy_a = tv[i].rdy;
            chk($sformatf("row%0d_valid", i), v_a, tv[i].ev);
            chk($sformatf("row%0d_mem_enable", i), me_a, tv[i].eme);
            chk($sformatf("row%0d_mem_addr", i), ma_a, tv[i].ea);
            chk($sformatf("row%0d_read_write", i), rw_a, 1);
            if (tv[i].ev) begin
                chk($sformatf("row%0d_data", i), d_a, tv[i].ed);
                chk($sformatf("row%0d_pc", i), p_a, tv[i].ep);
            end
            @(posedge clk);
            @(negedge clk);
        end

        // Asynchronous reset in the middle of a REQ with a non-empty queue.
        rdy_a = 0;
        @(posedge clk);
        #2;
        chk("t1_pre_mem_enable", me_a, 1);
        chk("t1_pre_valid", v_a, 1);
        rst_n = 1'b0;
        #1;
        chk("t1_valid", v_a, 0);
        chk("t1_data", d_a, 0);
        chk("t1_pc", p_a, 0);
        chk("t1_mem_addr", ma_a, 0);
        chk("t1_mem_enable", me_a, 0);
        chk("t1_read_write", rw_a, 1);
        do_reset();

        // fetch_en dropped during REQ: in-flight byte still lands, then no new reads.
        fe_a = 1; rdy_a = 1;
        @(negedge clk);
        chk("fe_req_mem_enable", me_a, 1);
        fe_a = 0;
        expect_byte(4'd0);
        drain(0, 1, 10, t);
        repeat (3) begin
            chk("fe_off_mem_enable", me_a, 0);
            @(negedge clk);
        end

        // Branch to 14 and wrap past 15.
        do_reset();
        br_a = 1; bra_a = 4'd14; fe_a = 1; rdy_a = 1;
        @(negedge clk);
        br_a = 0;
        chk("t4_idle_mem_enable", me_a, 0);
        chk("t4_idle_mem_addr", ma_a, 14);
        chk("t4_idle_valid", v_a, 0);
        @(negedge clk);
        chk("t4_req_mem_enable", me_a, 1);
        chk("t4_req_mem_addr", ma_a, 14);
        expect_byte(4'd14);
        expect_byte(4'd15);
        expect_byte(4'd0);
        expect_byte(4'd1);
        drain(0, 4, 40, t);
        fe_a = 0;

        // Branch in the same cycle as REQ: that read's data must be discarded.
        do_reset();
        fe_a = 1; rdy_a = 1;
        @(negedge clk);
        chk("brq_mem_enable", me_a, 1);
        chk("brq_mem_addr", ma_a, 0);
        br_a = 1; bra_a = 4'd5;
        @(negedge clk);
        br_a = 0;
        chk("brq_valid", v_a, 0);
        chk("brq_mem_enable_off", me_a, 0);
        chk("brq_mem_addr_new", ma_a, 5);
        expect_byte(4'd5);
        expect_byte(4'd6);
        drain(0, 2, 20, t);
        fe_a = 0;
        chk("sb_empty_a", sbq.size(), 0);

        // Latency 3: one byte every 4 cycles, junk on the bus before the last WAIT cycle.
        do_reset();
        s = cyc;
        fe_b = 1; rdy_b = 1;
        for (int k = 0; k < 3; k++) begin
            expect_byte(4'(k));
            drain(1, 1, 20, t);
            chk($sformatf("t6_pop%0d_cycle", k), t - s, 5 + 4 * k);
        end
        fe_b = 0;

        // Flush with two entries queued and a read in flight.
        do_reset();
        fe_b = 1; rdy_b = 0;
        repeat (9) @(negedge clk);
        chk("t5_inflight_mem_enable", me_b, 1);
        chk("t5_inflight_mem_addr", ma_b, 2);
        chk("t5_head_valid", v_b, 1);
        chk("t5_head_data", d_b, 8'h10);
        @(negedge clk);
        br_b = 1; bra_b = 4'd9;
        @(negedge clk);
        br_b = 0;
        chk("t5_flush_valid", v_b, 0);
        chk("t5_flush_mem_enable", me_b, 0);
        chk("t5_flush_mem_addr", ma_b, 9);
        rdy_b = 1;
        expect_byte(4'd9);
        expect_byte(4'd10);
        drain(1, 2, 40, t);
        fe_b = 0;
        chk("sb_empty_b", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
